// File: rtl/tick_pkg.sv
// Shared types and constants for the tick scheduler and its channels.
package tick_pkg;

  localparam int CNT_W_DEF = 28;
  localparam int NUM_CH    = 3;

  // Channel indices
  localparam int CH_PIX  = 0;
  localparam int CH_GAME = 1;
  localparam int CH_DB   = 2;

  // Reset divisors (period = divisor + 1 clk)
  localparam int unsigned DIV0_RST_DEF = 1;          // 25 MHz pixel enable
  localparam int unsigned DIV1_RST_DEF = 150000000;  // game/frame tick
  localparam int unsigned DIV2_RST_DEF = 25000;      // debounce sample tick

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } tick_state_e;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: counter, active and shadow divisor/enable, wrap detection,
// registered tick pulse and toggle output.
module tick_channel
  import tick_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DIV_RST = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,   // running and not paused
  input  logic             stopped,   // FSM in STOP or run just dropped
  input  logic             wr,        // accepted configuration for this channel
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_div,
  output logic             tick,
  output logic             tgl,
  output logic             pend
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] div_sh_q;
  logic             en_act_q, en_act_d;
  logic             en_sh_q;
  logic             pend_q;
  logic             tick_q;
  logic             tgl_q;
  logic             wrap;
  logic             apply;

  // Wrap/apply decode and next counter/active values. A pending shadow is
  // applied at a wrap so a period never mixes old and new divisors, or at
  // once when the channel cannot be counting (stopped or disabled).
  always_comb begin
    wrap      = advance & en_act_q & (cnt_q == div_act_q);
    apply     = pend_q & (wrap | stopped | ~en_act_q);
    div_act_d = div_act_q;
    en_act_d  = en_act_q;
    cnt_d     = cnt_q;
    if (apply) begin
      div_act_d = div_sh_q;
      en_act_d  = en_sh_q;
    end
    if (stopped || !en_act_q || wrap || apply) begin
      cnt_d = '0;
    end else if (advance) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter, active registers and registered tick/toggle outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_act_q <= DIV_RST;
      en_act_q  <= 1'b1;
      tick_q    <= 1'b0;
      tgl_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      en_act_q  <= en_act_d;
      tick_q    <= wrap;
      if (wrap) begin
        tgl_q <= ~tgl_q;
      end
    end
  end

  // Shadow registers and pending flag; a write can only arrive while
  // nothing is pending, so write and apply never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_sh_q <= DIV_RST;
      en_sh_q  <= 1'b1;
      pend_q   <= 1'b0;
    end else if (wr) begin
      div_sh_q <= wr_div;
      en_sh_q  <= wr_en;
      pend_q   <= 1'b1;
    end else if (apply) begin
      pend_q   <= 1'b0;
    end
  end

  assign tick = tick_q;
  assign tgl  = tgl_q;
  assign pend = pend_q;

endmodule

// File: rtl/tick_scheduler.sv
// Three-channel clock-enable generator with safe runtime divisor reload.
// Holds the run/stop FSM, the configuration handshake and busy reduction.
//
// Configuration handshake: a transfer happens on every clk edge where
// cfg_valid and cfg_ready are both high; cfg_ready is ~busy; the requester
// keeps cfg_valid and all cfg_* fields stable until that edge.
module tick_scheduler
  import tick_pkg::*;
#(
  parameter int          CNT_W    = CNT_W_DEF,
  parameter int unsigned DIV0_RST = DIV0_RST_DEF,
  parameter int unsigned DIV1_RST = DIV1_RST_DEF,
  parameter int unsigned DIV2_RST = DIV2_RST_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             pause,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_ch,
  input  logic             cfg_en,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_err,
  output logic [2:0]       tick,
  output logic [2:0]       tgl,
  output logic             busy,
  output tick_state_e      state_dbg
);

  tick_state_e       state_q, state_d;
  logic              stopped;
  logic              advance;
  logic              accept;
  logic [NUM_CH-1:0] wr;
  logic [NUM_CH-1:0] pend;
  logic              cfg_err_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STOP;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: RUN follows run; pause is a qualifier inside RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: if (run)  state_d = ST_RUN;
      ST_RUN:  if (!run) state_d = ST_STOP;
      default: state_d = ST_STOP;
    endcase
  end

  // Dropping run clears counters on the same edge, so stop is taken from
  // the live run level as well as the state.
  assign stopped = (state_q != ST_RUN) | ~run;
  assign advance = ~stopped & ~pause;

  assign busy      = |pend;
  assign cfg_ready = ~busy;
  assign accept    = cfg_valid & cfg_ready;

  // Per-channel write strobes; channel 3 matches none of them.
  always_comb begin
    wr = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      wr[n] = accept & (cfg_ch == 2'(n));
    end
  end

  // Illegal-channel error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= accept & (cfg_ch == 2'd3);
    end
  end

  assign cfg_err   = cfg_err_q;
  assign state_dbg = state_q;

  tick_channel #(.CNT_W(CNT_W), .DIV_RST(CNT_W'(DIV0_RST))) u_pix (
    .clk(clk), .rst_n(rst_n), .advance(advance), .stopped(stopped),
    .wr(wr[CH_PIX]), .wr_en(cfg_en), .wr_div(cfg_div),
    .tick(tick[CH_PIX]), .tgl(tgl[CH_PIX]), .pend(pend[CH_PIX])
  );

  tick_channel #(.CNT_W(CNT_W), .DIV_RST(CNT_W'(DIV1_RST))) u_game (
    .clk(clk), .rst_n(rst_n), .advance(advance), .stopped(stopped),
    .wr(wr[CH_GAME]), .wr_en(cfg_en), .wr_div(cfg_div),
    .tick(tick[CH_GAME]), .tgl(tgl[CH_GAME]), .pend(pend[CH_GAME])
  );

  tick_channel #(.CNT_W(CNT_W), .DIV_RST(CNT_W'(DIV2_RST))) u_db (
    .clk(clk), .rst_n(rst_n), .advance(advance), .stopped(stopped),
    .wr(wr[CH_DB]), .wr_en(cfg_en), .wr_div(cfg_div),
    .tick(tick[CH_DB]), .tgl(tgl[CH_DB]), .pend(pend[CH_DB])
  );

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with hand-computed tick timing.
module tb_tick_scheduler;
  import tick_pkg::*;

  localparam int CNT_W = 28;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             run = 1'b0;
  logic             pause = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [1:0]       cfg_ch = 2'd0;
  logic             cfg_en = 1'b0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic             cfg_err;
  logic [2:0]       tick;
  logic [2:0]       tgl;
  logic             busy;
  tick_state_e      state_dbg;

  int total = 0;
  int bad   = 0;

  tick_scheduler #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .pause(pause),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_en(cfg_en), .cfg_div(cfg_div), .cfg_err(cfg_err),
    .tick(tick), .tgl(tgl), .busy(busy), .state_dbg(state_dbg)
  );

  // Clock and overall time limit.
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Steps until tick[ch] is sampled high; returns the number of steps taken
  // (equal to bound if it never came).
  task automatic wait_tick(input int ch, input int bound, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[ch] && n < bound);
  endtask

  task automatic drive_cfg(input logic [1:0] ch, input logic en, input int unsigned div);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_en    = en;
    cfg_div   = CNT_W'(div);
  endtask

  initial begin
    int n;
    logic [2:0] seen;
    logic       tg;

    // Reset state
    step(); step();
    check("rst_tick", 32'(tick), 0);
    check("rst_tgl", 32'(tgl), 0);
    check("rst_err", 32'(cfg_err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(cfg_ready), 1);
    check("rst_state", 32'(state_dbg), 32'(ST_STOP));
    rst_n = 1'b1;
    step(); step();
    check("stop_tick", 32'(tick), 0);

    // Defaults: CH0 period 2, CH2 first tick 25001 clk after run sampled
    run = 1'b1;
    step();
    check("run_state", 32'(state_dbg), 32'(ST_RUN));
    step(); check("ch0_k1_tick", 32'(tick[0]), 0); check("ch0_k1_tgl", 32'(tgl[0]), 0);
    step(); check("ch0_k2_tick", 32'(tick[0]), 1); check("ch0_k2_tgl", 32'(tgl[0]), 1);
    step(); check("ch0_k3_tick", 32'(tick[0]), 0); check("ch0_k3_tgl", 32'(tgl[0]), 1);
    step(); check("ch0_k4_tick", 32'(tick[0]), 1); check("ch0_k4_tgl", 32'(tgl[0]), 0);
    wait_tick(2, 30000, n);
    check("ch2_first", 32'(n + 4), 25001);

    // Stop and program CH2 div=3: applies on the next clk while stopped
    run = 1'b0;
    step();
    check("stop_state", 32'(state_dbg), 32'(ST_STOP));
    check("stop_no_tick", 32'(tick), 0);
    drive_cfg(2'd2, 1'b1, 3);
    step();
    cfg_valid = 1'b0;
    check("stop_cfg_busy", 32'(busy), 1);
    check("stop_cfg_ready", 32'(cfg_ready), 0);
    step();
    check("stop_apply_busy", 32'(busy), 0);
    run = 1'b1;
    step();
    wait_tick(2, 100, n); check("div3_first", 32'(n), 4);
    wait_tick(2, 100, n); check("div3_period", 32'(n), 4);

    // Mid-period reprogram to div=5
    step();
    drive_cfg(2'd2, 1'b1, 5);
    step();
    cfg_valid = 1'b0;
    check("mid_busy_a", 32'(busy), 1);
    step();
    check("mid_busy_b", 32'(busy), 1);
    wait_tick(2, 100, n); check("mid_old_rest", 32'(n), 1);
    check("mid_apply_busy", 32'(busy), 0);
    wait_tick(2, 100, n); check("div5_period", 32'(n), 6);

    // Write accepted on the wrap edge: old period 6 kept once more
    for (int i = 0; i < 5; i++) step();
    drive_cfg(2'd2, 1'b1, 3);
    step();
    cfg_valid = 1'b0;
    check("coinc_tick", 32'(tick[2]), 1);
    check("coinc_busy", 32'(busy), 1);
    wait_tick(2, 100, n); check("coinc_old", 32'(n), 6);
    check("coinc_apply_busy", 32'(busy), 0);
    wait_tick(2, 100, n); check("coinc_new", 32'(n), 4);

    // Pause for 10 clk at CH2 cnt=2
    step(); step();
    pause = 1'b1;
    seen = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen |= tick;
    end
    pause = 1'b0;
    check("pause_ticks", 32'(seen), 0);
    wait_tick(2, 100, n); check("pause_resume", 32'(n), 2);

    // Illegal channel
    drive_cfg(2'd3, 1'b0, 7);
    step();
    cfg_valid = 1'b0;
    check("ill_err", 32'(cfg_err), 1);
    check("ill_ready", 32'(cfg_ready), 1);
    check("ill_busy", 32'(busy), 0);
    step();
    check("ill_err_once", 32'(cfg_err), 0);
    wait_tick(2, 100, n); check("ill_ch2_rest", 32'(n), 2);
    wait_tick(2, 100, n); check("ill_ch2_period", 32'(n), 4);
    wait_tick(0, 100, n);
    wait_tick(0, 100, n); check("ill_ch0_period", 32'(n), 2);

    // CH1: div=2 programmed in STOP, then disabled at its next wrap
    run = 1'b0;
    step();
    drive_cfg(2'd1, 1'b1, 2);
    step();
    cfg_valid = 1'b0;
    step();
    run = 1'b1;
    step();
    wait_tick(1, 100, n); check("ch1_first", 32'(n), 3);
    wait_tick(1, 100, n); check("ch1_period", 32'(n), 3);
    check("ch1_tgl_even", 32'(tgl[1]), 0);
    drive_cfg(2'd1, 1'b0, 2);
    step();
    cfg_valid = 1'b0;
    wait_tick(1, 100, n); check("ch1_last", 32'(n), 2);
    check("ch1_tgl_odd", 32'(tgl[1]), 1);
    check("ch1_busy", 32'(busy), 0);
    tg = tgl[1];
    seen = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      seen |= tick;
    end
    check("ch1_dis_tick", 32'(seen[1]), 0);
    check("ch1_dis_tgl", 32'(tgl[1]), 1);
    check("ch1_dis_tgl_hold", 32'(tgl[1] ^ tg), 0);

    // Asynchronous reset with a pending reload
    drive_cfg(2'd2, 1'b1, 9);
    step();
    cfg_valid = 1'b0;
    check("rr_busy", 32'(busy), 1);
    #3 rst_n = 1'b0;
    #1;
    check("rr_tick", 32'(tick), 0);
    check("rr_tgl", 32'(tgl), 0);
    check("rr_busy_clr", 32'(busy), 0);
    check("rr_ready", 32'(cfg_ready), 1);
    check("rr_err", 32'(cfg_err), 0);
    check("rr_state", 32'(state_dbg), 32'(ST_STOP));
    #2 rst_n = 1'b1;
    step();
    wait_tick(2, 30000, n); check("rr_ch2_default", 32'(n), 25001);
    wait_tick(0, 100, n);
    wait_tick(0, 100, n); check("rr_ch0_period", 32'(n), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
